fetch_bpred_stage: RTL
======================

Name: fetch_bpred_stage

Overview:
Parametrised instruction-fetch stage for the 5-stage RISC-V pipeline. It replaces the fixed PC+4 adder, PC mux, PC register and IF/ID register with one block that adds a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. It redirects fetch speculatively, recovers on mispredicts reported by EX, and keeps branch and mispredict statistics.

Parameters:
- PC_W, 9, program counter width in bits; PC_W >= IDX_W+3
- INS_W, 32, instruction width in bits
- BTB_DEPTH, 16, number of BTB entries; must be a power of 2; IDX_W = log2(BTB_DEPTH)
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall_i  in  1  hazard-detection stall; holds PC and IF/ID
- imem_addr_o  out  PC_W  fetch address, equal to the current PC
- imem_rdata_i  in  INS_W  instruction at imem_addr_o, valid in the same cycle
- res_valid_i  in  1  EX reports a resolved instruction this cycle
- res_is_branch_i  in  1  resolved instruction is a branch or jal
- res_pc_i  in  PC_W  PC of the resolved instruction
- res_taken_i  in  1  actual direction
- res_target_i  in  PC_W  actual taken target
- res_pred_taken_i  in  1  prediction carried down the pipe with the instruction
- res_pred_target_i  in  PC_W  predicted target carried down the pipe
- flush_o  out  1  mispredict; flush ID/EX
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_pc_o  out  PC_W  IF/ID PC
- ifid_instr_o  out  INS_W  IF/ID instruction
- ifid_pred_taken_o  out  1  prediction made for the instruction in IF/ID
- ifid_pred_target_o  out  PC_W  predicted target for the instruction in IF/ID
- branch_cnt_o  out  CNT_W  number of resolved branches
- mispred_cnt_o  out  CNT_W  number of mispredicts

Behaviour:
- Reset values:
  - PC = RESET_PC.
  - All IF/ID outputs = 0 (instr = 0 acts as a bubble).
  - All BTB valid bits = 0.
  - Both performance counters = 0.
  - flush_o = 0 while reset is high.
- Mispredict (combinational):
  - mispred = res_valid_i & res_is_branch_i & ((res_taken_i != res_pred_taken_i) | (res_taken_i & res_target_i != res_pred_target_i)).
  - flush_o = mispred.
- BTB lookup (combinational on PC):
  - idx = PC[IDX_W+1:2]; tag = PC[PC_W-1:IDX_W+2].
  - hit = valid[idx] & tag match.
  - pred_taken = hit & ctr[idx][1]; pred_target = target[idx].
- Next-PC priority, registered at each edge:
  1. reset -> RESET_PC.
  2. mispred -> (res_taken_i ? res_target_i : res_pc_i+4).
  3. stall_i -> hold PC.
  4. pred_taken -> pred_target.
  5. otherwise PC+4.
  - All PC arithmetic wraps modulo 2^PC_W.
- IF/ID register, same priority:
  - reset or mispred -> bubble (valid=0, pc=0, instr=0, pred=0).
  - stall_i -> hold.
  - otherwise load {1, PC, imem_rdata_i, pred_taken, pred_target}.
  - Mispredict overrides stall.
- Latency: one cycle from PC to IF/ID. Redirect penalty: the IF/ID contents at the mispredict edge become a bubble, and the PC at the next edge is the correct one.
- BTB update, on the edge when res_valid_i & res_is_branch_i:
  - Hit on res_pc_i: counter saturating increment if taken, decrement if not (range 0..3). Target rewritten when taken.
  - Miss and taken: allocate the entry (overwrite whatever is there) with valid=1, new tag, target=res_target_i, ctr=2'b10.
  - Miss and not taken: no change.
  - Non-branch resolves do not touch the BTB.
- Simultaneous lookup and update to the same index: the lookup sees the old contents (no bypass). The update is visible from the next cycle.
- Counters:
  - branch_cnt_o increments on each res_valid_i & res_is_branch_i.
  - mispred_cnt_o increments on each mispred.
  - Both saturate at all-ones and do not wrap.
- stall_i does not block BTB updates or counters.
- Reset mid-operation discards all prediction state on the same edge.

Decomposition:
- Package bpred_pkg:
  - btb_entry_t struct {valid, tag, target, ctr[1:0]}.
  - if_id_pred_t struct extending the existing IF/ID fields with valid, pred_taken, pred_target.
  - Counter encoding constants: SNT=0, WNT=1, WT=2, ST=3.
- Sub-module btb_table: storage array, combinational read port, one synchronous write port, valid-clear on reset. Parametrised by BTB_DEPTH, tag width and PC_W.

Test Plan:
- Sequential fetch: reset, then 5 cycles with no resolves -> imem_addr_o = 0,4,8,12,16; IF/ID pc lags by 1 cycle; ifid_valid_o=1 from the 2nd cycle.
- Taken loop: backward branch at 0x20 to 0x10 resolves taken with pred_taken=0 -> flush_o=1, next PC=0x10, BTB allocated with ctr=2. The next fetch of 0x20 predicts taken, target 0x10, with no flush.
- Not-taken mispredict: the branch at 0x20 later resolves not taken with pred_taken=1 -> flush_o=1, PC=0x24, IF/ID bubble, ctr 2->1. A second not-taken resolve -> ctr=0, and it saturates at 0.
- Stall vs flush: stall_i=1 for 3 cycles -> PC and IF/ID hold. Asserting mispred during the stall -> redirect and bubble win on that edge.
- Aliasing: PCs 0x20 and 0x20+4*BTB_DEPTH*k (wrapped) share an index. The second allocation evicts the first, and a fetch of the first then misses -> pred_taken=0.
- Counters: 10 branch resolves with 3 mispredicts -> branch_cnt_o=10, mispred_cnt_o=3. With CNT_W=4, 20 resolves -> 15 (saturated).

Source files
------------

// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared 2-bit predictor encodings and counter update helper
package bpred_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// rtl/btb_table.sv - direct-mapped BTB storage: async fetch/update read ports, one sync write port
module btb_table #(
  parameter int BTB_DEPTH = 16,
  parameter int TAG_W     = 3,
  parameter int PC_W      = 9,
  localparam int IDX_W    = $clog2(BTB_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] fetch_idx,
  output logic             fetch_valid,
  output logic [TAG_W-1:0] fetch_tag,
  output logic [PC_W-1:0]  fetch_target,
  output logic [1:0]       fetch_ctr,
  input  logic [IDX_W-1:0] upd_idx,
  output logic             upd_valid,
  output logic [TAG_W-1:0] upd_tag,
  output logic [PC_W-1:0]  upd_target,
  output logic [1:0]       upd_ctr,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  logic [1:0]       wr_ctr
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t mem [BTB_DEPTH];

  assign fetch_valid  = mem[fetch_idx].valid;
  assign fetch_tag    = mem[fetch_idx].tag;
  assign fetch_target = mem[fetch_idx].target;
  assign fetch_ctr    = mem[fetch_idx].ctr;

  assign upd_valid    = mem[upd_idx].valid;
  assign upd_tag      = mem[upd_idx].tag;
  assign upd_target   = mem[upd_idx].target;
  assign upd_ctr      = mem[upd_idx].ctr;

  // Writes always land on the update index; reads see old contents until the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      mem[upd_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: wr_ctr};
    end
  end

endmodule

// File: rtl/fetch_bpred_stage.sv
// rtl/fetch_bpred_stage.sv - IF stage with BTB + 2-bit prediction, mispredict recovery and branch statistics
module fetch_bpred_stage
  import bpred_pkg::*;
#(
  parameter int              PC_W      = 9,
  parameter int              INS_W     = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [INS_W-1:0] imem_rdata_i,
  input  logic             res_valid_i,
  input  logic             res_is_branch_i,
  input  logic [PC_W-1:0]  res_pc_i,
  input  logic             res_taken_i,
  input  logic [PC_W-1:0]  res_target_i,
  input  logic             res_pred_taken_i,
  input  logic [PC_W-1:0]  res_pred_target_i,
  output logic             flush_o,
  output logic             ifid_valid_o,
  output logic [PC_W-1:0]  ifid_pc_o,
  output logic [INS_W-1:0] ifid_instr_o,
  output logic             ifid_pred_taken_o,
  output logic [PC_W-1:0]  ifid_pred_target_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
  } if_id_pred_t;

  logic [PC_W-1:0]  pc_q, pc_d, pc_plus4;
  if_id_pred_t      ifid_q, ifid_d;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  logic             f_valid, u_valid;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic [PC_W-1:0]  f_target, u_target;
  logic [1:0]       f_ctr, u_ctr;

  logic             hit, pred_taken, res_branch, mispred, u_hit, wr_en;
  logic [PC_W-1:0]  wr_target;
  logic [1:0]       wr_ctr;
  logic             unused_ctr_lsb;

  btb_table #(.BTB_DEPTH(BTB_DEPTH), .TAG_W(TAG_W), .PC_W(PC_W)) u_btb (
    .clk          (clk),
    .reset        (reset),
    .fetch_idx    (pc_q[IDX_W+1:2]),
    .fetch_valid  (f_valid),
    .fetch_tag    (f_tag),
    .fetch_target (f_target),
    .fetch_ctr    (f_ctr),
    .upd_idx      (res_pc_i[IDX_W+1:2]),
    .upd_valid    (u_valid),
    .upd_tag      (u_tag),
    .upd_target   (u_target),
    .upd_ctr      (u_ctr),
    .wr_en        (wr_en),
    .wr_tag       (res_pc_i[PC_W-1:IDX_W+2]),
    .wr_target    (wr_target),
    .wr_ctr       (wr_ctr)
  );

  assign unused_ctr_lsb = f_ctr[0];

  assign res_branch = res_valid_i & res_is_branch_i;
  assign mispred    = res_branch & ((res_taken_i != res_pred_taken_i) |
                                    (res_taken_i & (res_target_i != res_pred_target_i)));
  assign flush_o    = mispred & ~reset;

  assign hit        = f_valid & (f_tag == pc_q[PC_W-1:IDX_W+2]);
  assign pred_taken = hit & f_ctr[1];
  assign pc_plus4   = pc_q + PC_W'(4);

  // A miss only allocates when taken; a hit keeps its old target on not-taken.
  assign u_hit     = u_valid & (u_tag == res_pc_i[PC_W-1:IDX_W+2]);
  assign wr_en     = res_branch & (u_hit | res_taken_i);
  assign wr_ctr    = u_hit ? ctr_next(u_ctr, res_taken_i) : WT;
  assign wr_target = (u_hit & ~res_taken_i) ? u_target : res_target_i;

  always_comb begin
    pc_d   = pc_plus4;
    ifid_d = '{valid: 1'b1, pc: pc_q, instr: imem_rdata_i,
               pred_taken: pred_taken, pred_target: f_target};
    if (mispred) begin
      pc_d   = res_taken_i ? res_target_i : res_pc_i + PC_W'(4);
      ifid_d = '0;
    end else if (stall_i) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
    end else if (pred_taken) begin
      pc_d   = f_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifid_q        <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      if (res_branch && branch_cnt_q != '1) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (mispred && mispred_cnt_q != '1) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  assign imem_addr_o        = pc_q;
  assign ifid_valid_o       = ifid_q.valid;
  assign ifid_pc_o          = ifid_q.pc;
  assign ifid_instr_o       = ifid_q.instr;
  assign ifid_pred_taken_o  = ifid_q.pred_taken;
  assign ifid_pred_target_o = ifid_q.pred_target;
  assign branch_cnt_o       = branch_cnt_q;
  assign mispred_cnt_o      = mispred_cnt_q;

endmodule
